// File: rtl/deserializer_unit_cell.sv
// deserializer_unit_cell
//   Recovers WIDTH-bit words from a framed, LSB-first serial stream. A frame
//   is FRAME bit periods long. The first WIDTH bits carry the word and the
//   rest are gap. SYNC marks bit 0. Once locked, the cell freewheels on its
//   own bit counter, so SYNC is optional on later frames.
//
// Ports
//   CLK        in   single clock, rising edge
//   RESET      in   asynchronous, active-low reset
//   SERIAL_IN  in   serial data, one bit per CLK, LSB first
//   SYNC       in   frame marker, high during bit 0
//   PAR_READY  in   downstream accepts PAR_OUT when high with PAR_VALID
//   CLR_OVF    in   synchronous clear of OVERFLOW
//   PAR_OUT    out  last accepted word, registered
//   PAR_VALID  out  PAR_OUT holds an unconsumed word
//   LOCKED     out  frame alignment acquired
//   SYNC_ERR   out  one-cycle pulse after a misplaced SYNC
//   OVERFLOW   out  sticky; a word was dropped because the output was full
//
// state | meaning
// HUNT  | unlocked, waiting for SYNC; SERIAL_IN ignored
// DATA  | capturing word bit BITCNT from SERIAL_IN
// GAP   | word complete, counting out the rest of the frame

module deserializer_unit_cell #(
  parameter int WIDTH = 16,
  parameter int FRAME = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  input  logic             SYNC,
  input  logic             PAR_READY,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             PAR_VALID,
  output logic             LOCKED,
  output logic             SYNC_ERR,
  output logic             OVERFLOW
);

  localparam int BITCNT_W = $clog2(FRAME);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  // Counts down after a SYNC error. A second error while it is non-zero
  // drops lock.
  logic [BITCNT_W-1:0] win_q, win_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic [WIDTH-1:0]    par_out_d;
  logic                par_valid_d, sync_err_d, overflow_d;
  logic                take_bit, bit0, complete, ovf_set;
  logic [BITCNT_W-1:0] idx;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    win_d      = (win_q != '0) ? win_q - 1'b1 : win_q;
    sync_err_d = 1'b0;
    take_bit   = 1'b0;
    bit0       = 1'b0;

    case (state_q)
      HUNT: begin
        if (SYNC) begin
          take_bit = 1'b1;
          bit0     = 1'b1;
          bitcnt_d = BITCNT_W'(1);
          state_d  = DATA;
        end
      end
      DATA, GAP: begin
        if (SYNC && (bitcnt_q != '0)) begin
          sync_err_d = 1'b1;
          if (win_q != '0) begin
            // Second misplaced SYNC inside one frame: the alignment cannot
            // be trusted, so go back to hunting. This SYNC is not bit 0.
            state_d  = HUNT;
            bitcnt_d = '0;
            win_d    = '0;
          end else begin
            // Realign to this SYNC. The partial word is dropped.
            win_d    = BITCNT_W'(FRAME - 1);
            take_bit = 1'b1;
            bit0     = 1'b1;
            bitcnt_d = BITCNT_W'(1);
            state_d  = DATA;
          end
        end else if (state_q == DATA) begin
          take_bit = 1'b1;
          bit0     = (bitcnt_q == '0);
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BITCNT_W'(WIDTH - 1)) state_d = GAP;
        end else begin
          // Freewheel: the wrap to 0 makes the next cycle bit 0.
          if (bitcnt_q == BITCNT_W'(FRAME - 1)) begin
            bitcnt_d = '0;
            state_d  = DATA;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = HUNT;
        bitcnt_d = '0;
      end
    endcase

    idx      = bit0 ? '0 : bitcnt_q;
    complete = take_bit && (idx == BITCNT_W'(WIDTH - 1));
    if (complete) state_d = GAP;

    // Bit 0 starts a fresh word. No stale bits from an earlier word survive.
    word_d = word_q;
    if (take_bit) begin
      if (bit0) word_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (idx == BITCNT_W'(i)) word_d[i] = SERIAL_IN;
      end
    end

    par_out_d   = PAR_OUT;
    par_valid_d = PAR_VALID;
    ovf_set     = 1'b0;
    if (complete) begin
      if (!PAR_VALID || PAR_READY) begin
        par_out_d   = word_d;
        par_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (PAR_VALID && PAR_READY) begin
      par_valid_d = 1'b0;
    end
    // If a set and a clear arrive together, the set wins.
    overflow_d = ovf_set | (OVERFLOW & ~CLR_OVF);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= HUNT;
      bitcnt_q  <= '0;
      win_q     <= '0;
      word_q    <= '0;
      PAR_OUT   <= '0;
      PAR_VALID <= 1'b0;
      SYNC_ERR  <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      win_q     <= win_d;
      word_q    <= word_d;
      PAR_OUT   <= par_out_d;
      PAR_VALID <= par_valid_d;
      SYNC_ERR  <= sync_err_d;
      OVERFLOW  <= overflow_d;
    end
  end

  assign LOCKED = (state_q != HUNT);

endmodule

// File: tb/tb_deserializer_unit_cell.sv
module tb_deserializer_unit_cell;

  localparam int W = 16;
  localparam int F = 32;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         SERIAL_IN = 1'b0;
  logic         SYNC = 1'b0;
  logic         PAR_READY = 1'b0;
  logic         CLR_OVF = 1'b0;
  logic [W-1:0] PAR_OUT;
  logic         PAR_VALID;
  logic         LOCKED;
  logic         SYNC_ERR;
  logic         OVERFLOW;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: frame position plus an assembled word and output state.
  logic         m_locked;
  int           m_pos;
  logic [W-1:0] m_word;
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_ovf;
  logic         m_err;
  longint       m_cyc;
  longint       m_last_err;

  logic [W-1:0] wa, wb;

  deserializer_unit_cell #(.WIDTH(W), .FRAME(F)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SERIAL_IN(SERIAL_IN),
    .SYNC(SYNC),
    .PAR_READY(PAR_READY),
    .CLR_OVF(CLR_OVF),
    .PAR_OUT(PAR_OUT),
    .PAR_VALID(PAR_VALID),
    .LOCKED(LOCKED),
    .SYNC_ERR(SYNC_ERR),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_pos      = 0;
    m_word     = '0;
    m_out      = '0;
    m_valid    = 1'b0;
    m_ovf      = 1'b0;
    m_err      = 1'b0;
    m_cyc      = 0;
    m_last_err = -1000000;
  endtask

  task automatic model_step(input logic sin, input logic sync, input logic rdy, input logic clr);
    logic sample, complete, err, ovf_set;
    sample = 1'b0; complete = 1'b0; err = 1'b0; ovf_set = 1'b0;
    if (!m_locked) begin
      if (sync) begin
        m_locked = 1'b1;
        m_pos    = 0;
      end
    end else if (sync && m_pos != 0) begin
      err = 1'b1;
      if (m_cyc - m_last_err < F) begin
        m_locked   = 1'b0;
        m_last_err = -1000000;
      end else begin
        m_last_err = m_cyc;
        m_pos      = 0;
      end
    end
    sample = m_locked && (m_pos < W);
    if (sample) begin
      if (m_pos == 0) m_word = '0;
      m_word[m_pos] = sin;
      complete = (m_pos == W - 1);
    end
    if (m_locked) m_pos = (m_pos + 1) % F;
    if (complete) begin
      if (!m_valid || rdy) begin
        m_out   = m_word;
        m_valid = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_err = err;
    m_cyc++;
  endtask

  task automatic check_outputs();
    cmp("par_out", 64'(PAR_OUT), 64'(m_out));
    cmp("par_valid", 64'(PAR_VALID), 64'(m_valid));
    cmp("locked", 64'(LOCKED), 64'(m_locked));
    cmp("sync_err", 64'(SYNC_ERR), 64'(m_err));
    cmp("overflow", 64'(OVERFLOW), 64'(m_ovf));
  endtask

  // Called at a falling edge: drive, advance the model, then check after the edge.
  task automatic tick(input logic sin, input logic sync, input logic rdy, input logic clr);
    SERIAL_IN = sin;
    SYNC      = sync;
    PAR_READY = rdy;
    CLR_OVF   = clr;
    model_step(sin, sync, rdy, clr);
    @(negedge CLK);
    check_outputs();
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    cmp("rst_par_out", 64'(PAR_OUT), 64'd0);
    cmp("rst_par_valid", 64'(PAR_VALID), 64'd0);
    cmp("rst_locked", 64'(LOCKED), 64'd0);
    cmp("rst_sync_err", 64'(SYNC_ERR), 64'd0);
    cmp("rst_overflow", 64'(OVERFLOW), 64'd0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // rdy_mode: 0 never ready, 1 always ready, 2 ready only on the last data bit
  task automatic send_frame(input logic [W-1:0] word, input logic do_sync, input int rdy_mode,
                            input logic clr_first, input logic do_lit, input logic [W-1:0] lit_out);
    logic rdy;
    for (int p = 0; p < F; p++) begin
      rdy = (rdy_mode == 1) || (rdy_mode == 2 && p == W - 1);
      tick((p < W) ? word[p] : rbit(), do_sync && p == 0, rdy, clr_first && p == 0);
      if (clr_first && p == 0) cmp("ovf_cleared", 64'(OVERFLOW), 64'd0);
      if (do_lit && p == W - 1) begin
        cmp("word_valid", 64'(PAR_VALID), 64'd1);
        cmp("word_out", 64'(PAR_OUT), 64'(lit_out));
      end
      if (do_lit && rdy_mode == 1 && p == W) cmp("valid_one_cycle", 64'(PAR_VALID), 64'd0);
    end
  endtask

  initial begin
    model_reset();
    #1 RESET = 1'b0;
    @(negedge CLK);
    cmp("init_par_out", 64'(PAR_OUT), 64'd0);
    cmp("init_par_valid", 64'(PAR_VALID), 64'd0);
    cmp("init_locked", 64'(LOCKED), 64'd0);
    cmp("init_overflow", 64'(OVERFLOW), 64'd0);
    check_outputs();
    @(negedge CLK);
    RESET = 1'b1;

    // Idle without SYNC: stays unlocked.
    for (int i = 0; i < 5; i++) tick(rbit(), 1'b0, 1'b1, 1'b0);
    cmp("hunt_unlocked", 64'(LOCKED), 64'd0);

    // Lock and capture
    send_frame(16'hA5C3, 1'b1, 1, 1'b0, 1'b1, 16'hA5C3);

    // Freewheel
    send_frame(16'h0001, 1'b0, 1, 1'b0, 1'b1, 16'h0001);
    send_frame(16'h8000, 1'b0, 1, 1'b0, 1'b1, 16'h8000);
    send_frame(16'hFFFF, 1'b0, 1, 1'b0, 1'b1, 16'hFFFF);
    cmp("freewheel_locked", 64'(LOCKED), 64'd1);

    // Backpressure and overflow
    send_frame(16'h1234, 1'b0, 0, 1'b0, 1'b1, 16'h1234);
    cmp("bp_no_ovf_yet", 64'(OVERFLOW), 64'd0);
    send_frame(16'h5678, 1'b0, 0, 1'b0, 1'b1, 16'h1234);
    cmp("bp_ovf_set", 64'(OVERFLOW), 64'd1);
    send_frame(16'h0F0F, 1'b0, 1, 1'b1, 1'b1, 16'h0F0F);

    // Accept and complete on the same edge
    send_frame(16'hAAAA, 1'b0, 0, 1'b0, 1'b1, 16'hAAAA);
    send_frame(16'h5555, 1'b0, 2, 1'b0, 1'b1, 16'h5555);
    cmp("simul_no_ovf", 64'(OVERFLOW), 64'd0);
    send_frame(16'h3C3C, 1'b0, 1, 1'b0, 1'b1, 16'h3C3C);

    // Misplaced SYNC, then a second one inside the same frame period
    wa = 16'hBEEF;
    wb = 16'h1357;
    for (int p = 0; p < 7; p++) tick(wa[p], 1'b0, 1'b1, 1'b0);
    tick(wb[0], 1'b1, 1'b1, 1'b0);
    cmp("mis_sync_err", 64'(SYNC_ERR), 64'd1);
    cmp("mis_still_locked", 64'(LOCKED), 64'd1);
    tick(wb[1], 1'b0, 1'b1, 1'b0);
    cmp("mis_err_one_cycle", 64'(SYNC_ERR), 64'd0);
    for (int p = 2; p < W; p++) tick(wb[p], 1'b0, 1'b1, 1'b0);
    cmp("realign_valid", 64'(PAR_VALID), 64'd1);
    cmp("realign_out", 64'(PAR_OUT), 64'(16'h1357));
    for (int p = 0; p < 4; p++) tick(rbit(), 1'b0, 1'b1, 1'b0);
    tick(rbit(), 1'b1, 1'b1, 1'b0);
    cmp("second_err_unlock", 64'(LOCKED), 64'd0);
    cmp("second_err_pulse", 64'(SYNC_ERR), 64'd1);
    for (int i = 0; i < 40; i++) tick(rbit(), 1'b0, 1'b1, 1'b0);
    cmp("hunt_no_word", 64'(PAR_VALID), 64'd0);

    // Relock
    send_frame(16'hC0DE, 1'b1, 1, 1'b0, 1'b1, 16'hC0DE);

    // Reset in the middle of a word with a word pending
    send_frame(16'h7E57, 1'b0, 0, 1'b0, 1'b1, 16'h7E57);
    for (int p = 0; p < 10; p++) tick(rbit(), 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) tick(rbit(), 1'b0, 1'b1, 1'b0);
    send_frame(16'h4242, 1'b1, 1, 1'b0, 1'b1, 16'h4242);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      logic s;
      if ($urandom_range(0, 1999) == 0) do_reset();
      if (m_locked && m_pos == 0) s = rbit();
      else s = ($urandom_range(0, 79) == 0);
      tick(rbit(), s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/deserializer_unit_cell.md
DESERIALIZER_UNIT_CELL -- requirements
Module: deserializer_unit_cell

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter FRAME, default 32, bit periods per frame; FRAME > WIDTH, FRAME <= 64.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 SERIAL_IN  input  1  serial data, one bit per CLK, LSB first.
REQ-006 SYNC  input  1  frame marker, high in the cycle SERIAL_IN carries bit 0.
REQ-007 PAR_READY  input  1  downstream accepts PAR_OUT when high with PAR_VALID.
REQ-008 CLR_OVF  input  1  synchronous clear of OVERFLOW.
REQ-009 PAR_OUT  output  WIDTH  reconstructed word, registered.
REQ-010 PAR_VALID  output  1  PAR_OUT holds an unconsumed word.
REQ-011 LOCKED  output  1  frame alignment acquired.
REQ-012 SYNC_ERR  output  1  one-cycle pulse on misplaced SYNC.
REQ-013 OVERFLOW  output  1  sticky, word dropped because output was full.

Function
REQ-014 SHALL implement states HUNT, DATA, GAP with a bit counter BITCNT of width ceil(log2(FRAME)).
REQ-015 HUNT: SYNC=1 samples SERIAL_IN into word bit 0, sets BITCNT=1, LOCKED=1, goes to DATA; SYNC=0 -> remain, ignore SERIAL_IN.
REQ-016 DATA: each cycle samples SERIAL_IN into word bit BITCNT, BITCNT+1; on sampling bit WIDTH-1 go to GAP.
REQ-017 GAP: SERIAL_IN ignored; BITCNT increments; at BITCNT=FRAME-1 BITCNT wraps to 0 and next cycle is treated as bit 0 (DATA), SYNC optional (freewheel).
REQ-018 Word completion: PAR_OUT loads the full word and PAR_VALID rises at the edge sampling bit WIDTH-1 (visible the next cycle; latency 1 cycle after last bit).
REQ-019 Handshake: PAR_VALID & PAR_READY in a cycle clears PAR_VALID at that edge unless a new word completes the same edge, in which case PAR_OUT loads the new word and PAR_VALID stays 1.
REQ-020 PAR_OUT SHALL remain stable while PAR_VALID=1 and PAR_READY=0.
REQ-021 Word completing while PAR_VALID=1 and PAR_READY=0: new word discarded, PAR_OUT unchanged, OVERFLOW set to 1.
REQ-022 OVERFLOW clears on CLR_OVF=1 only; if set-condition and CLR_OVF coincide, OVERFLOW=1.
REQ-023 SYNC=1 when locked and BITCNT != 0 (DATA or GAP): SYNC_ERR pulses 1 cycle, partial word discarded, SERIAL_IN taken as bit 0, BITCNT=1, state DATA; LOCKED stays 1.
REQ-024 SYNC=1 at BITCNT=0 while locked: normal, no SYNC_ERR.
REQ-025 Two consecutive SYNC errors within one frame period SHALL drop LOCKED to 0 and return to HUNT (second SYNC not used as bit 0).
REQ-026 Unsampled word bits never reach PAR_OUT; a word is emitted only after all WIDTH bits captured since bit 0.

Reset
REQ-027 RESET=0 asynchronously forces: state HUNT, BITCNT=0, shift register 0, PAR_OUT=0, PAR_VALID=0, LOCKED=0, SYNC_ERR=0, OVERFLOW=0.
REQ-028 Reset mid-word discards the partial word; after release, operation restarts in HUNT awaiting SYNC.
REQ-029 RESET deassertion takes effect on the first CLK edge after release; no word emitted within that edge.

Verification
REQ-030 Lock/capture: SYNC at cycle 0, bits LSB-first of 16'hA5C3, PAR_READY=1 -> PAR_OUT=16'hA5C3, PAR_VALID=1 for exactly one cycle, 16 cycles after SYNC.
REQ-031 Freewheel: SYNC only on first frame, words 16'h0001, 16'h8000, 16'hFFFF in consecutive 32-cycle frames -> all three emitted at 32-cycle spacing, LOCKED=1 throughout.
REQ-032 Backpressure: PAR_READY=0 for two frames carrying 16'h1234, 16'h5678 -> PAR_OUT=16'h1234 held, OVERFLOW=1 at second completion; CLR_OVF pulse -> OVERFLOW=0.
REQ-033 Misplaced SYNC: SYNC at bit 7 of a frame -> SYNC_ERR one-cycle pulse, no word for the aborted frame, next word aligned to new SYNC; second misplaced SYNC within 32 cycles -> LOCKED=0, state HUNT.
REQ-034 Reset mid-operation: RESET=0 at bit 10 with PAR_VALID=1 -> all outputs 0 immediately (asynchronously); after release, no output until next SYNC plus 16 cycles.
REQ-035 Simultaneous accept/complete: PAR_READY=1 on the cycle a new word completes -> PAR_VALID stays 1, PAR_OUT updates to new word, OVERFLOW=0.
